// File: rtl/vid_pixfeed_pkg.sv
// Shared video definitions for the pixel feed path.
//   VID_BPC       default bits per colour component
//   feed_state_t  alignment FSM state encoding {SYNC, ARMED, RUN}
//   vid_entry_t   FIFO entry layout {sof, pixel}, pixel packed {red,grn,blu}
//   vid_entry_w   entry width for an arbitrary bits-per-colour setting
package vid_pixfeed_pkg;

  localparam int unsigned VID_BPC = 4;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } feed_state_t;

  // Reference layout at the default BPC; parameterised users keep the same
  // ordering: sof in the MSB, pixel below it.
  typedef struct packed {
    logic                   sof;
    logic [3*VID_BPC-1:0]   pixel;
  } vid_entry_t;

  function automatic int unsigned vid_entry_w(input int unsigned bpc);
    return 3 * bpc + 1;
  endfunction

endpackage

// File: rtl/vid_pixfifo.sv
// First-word-fall-through FIFO for {sof,pixel} entries.
//   i_pixclk, i_reset : clock, asynchronous active-high reset
//   i_wr, i_data      : write request and entry; accepted only when o_ready
//   o_ready           : not full
//   i_pop             : remove the head entry; ignored when empty
//   o_empty, o_data   : head entry, valid whenever !o_empty
//   o_fill            : occupancy, 0 .. 2^LGFIFO
module vid_pixfifo #(
  parameter int unsigned DW     = 13,
  parameter int unsigned LGFIFO = 10
) (
  input  logic              i_pixclk,
  input  logic              i_reset,
  input  logic              i_wr,
  input  logic [DW-1:0]     i_data,
  output logic              o_ready,
  input  logic              i_pop,
  output logic              o_empty,
  output logic [DW-1:0]     o_data,
  output logic [LGFIFO:0]   o_fill
);

  localparam int unsigned DEPTH = 1 << LGFIFO;

  logic [DW-1:0]   mem [DEPTH];
  logic [LGFIFO:0] wr_ptr;
  logic [LGFIFO:0] rd_ptr;
  logic [LGFIFO:0] fill;
  logic            do_wr;
  logic            do_pop;

  // Pointers carry one extra wrap bit, so their difference spans 0..DEPTH.
  assign fill    = wr_ptr - rd_ptr;
  assign o_fill  = fill;
  // fill never exceeds DEPTH, so its MSB alone flags the full condition.
  assign o_ready = ~fill[LGFIFO];
  assign o_empty = (fill == '0);

  assign do_wr  = i_wr && o_ready;
  assign do_pop = i_pop && !o_empty;

  always_ff @(posedge i_pixclk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr)
        wr_ptr <= wr_ptr + {{LGFIFO{1'b0}}, 1'b1};
      if (do_pop)
        rd_ptr <= rd_ptr + {{LGFIFO{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge i_pixclk) begin
    if (do_wr)
      mem[wr_ptr[LGFIFO-1:0]] <= i_data;
  end

  // Head is read straight from storage; empty is derived from registered
  // pointers, so a fresh write never shows up until the following cycle.
  assign o_data = mem[rd_ptr[LGFIFO-1:0]];

endmodule

// File: rtl/vid_pixfeed.sv
// Pixel feed between an upstream pixel source and a VGA timing stage.
// Pixels are buffered in vid_pixfifo; an alignment FSM discards data until a
// start-of-frame pixel reaches the head, waits for the downstream frame
// boundary, then feeds one pixel per i_rd while checking frame alignment.
//   i_pixclk, i_reset  : clock, asynchronous active-high reset
//   i_valid, o_ready   : upstream handshake
//   i_pixel, i_sof     : upstream pixel {red,grn,blu} and start-of-frame mark
//   i_rd               : downstream consumed the presented pixel
//   i_newframe         : downstream end-of-last-visible-row pulse
//   o_rgb_pix          : presented pixel (0 unless running with data)
//   o_err              : one-cycle pulse on loss of alignment
//   o_fill             : FIFO occupancy
module vid_pixfeed
  import vid_pixfeed_pkg::*;
#(
  parameter  int unsigned BPC    = VID_BPC,
  parameter  int unsigned LGFIFO = 10,
  localparam int unsigned PW     = 3 * BPC
) (
  input  logic              i_pixclk,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [PW-1:0]     i_pixel,
  input  logic              i_sof,
  input  logic              i_rd,
  input  logic              i_newframe,
  output logic [PW-1:0]     o_rgb_pix,
  output logic              o_err,
  output logic [LGFIFO:0]   o_fill
);

  localparam int unsigned EW = PW + 1;

  feed_state_t   state;
  feed_state_t   state_nx;
  logic          expect_sof;
  logic          expect_nx;
  logic          err_nx;
  logic          pop;
  logic          empty;
  logic [EW-1:0] head;
  logic          head_sof;
  logic [PW-1:0] head_pix;

  vid_pixfifo #(
    .DW     (EW),
    .LGFIFO (LGFIFO)
  ) u_fifo (
    .i_pixclk (i_pixclk),
    .i_reset  (i_reset),
    .i_wr     (i_valid),
    .i_data   ({i_sof, i_pixel}),
    .o_ready  (o_ready),
    .i_pop    (pop),
    .o_empty  (empty),
    .o_data   (head),
    .o_fill   (o_fill)
  );

  assign head_sof = head[PW];
  assign head_pix = head[PW-1:0];

  assign o_rgb_pix = (state == RUN && !empty) ? head_pix : '0;

  always_ff @(posedge i_pixclk or posedge i_reset) begin
    if (i_reset) begin
      state      <= SYNC;
      expect_sof <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      state      <= state_nx;
      expect_sof <= expect_nx;
      o_err      <= err_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    expect_nx = expect_sof;
    err_nx    = 1'b0;
    pop       = 1'b0;

    unique case (state)
      SYNC: begin
        if (!empty) begin
          if (head_sof)
            state_nx = ARMED;
          else
            pop = 1'b1;
        end
      end

      ARMED: begin
        if (i_newframe) begin
          state_nx  = RUN;
          expect_nx = 1'b1;
        end
      end

      RUN: begin
        if (i_rd) begin
          if (empty || (head_sof != expect_sof)) begin
            err_nx    = 1'b1;
            state_nx  = SYNC;
            expect_nx = 1'b0;
          end else begin
            pop = 1'b1;
            // A frame boundary coinciding with a good read arms the sof
            // check for the entry behind the one being consumed.
            expect_nx = i_newframe;
          end
        end else if (i_newframe) begin
          if (!empty && head_sof) begin
            expect_nx = 1'b1;
          end else begin
            err_nx    = 1'b1;
            state_nx  = SYNC;
            expect_nx = 1'b0;
          end
        end
      end

      default: begin
        state_nx  = SYNC;
        expect_nx = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_vid_pixfeed.sv
module tb_vid_pixfeed;
  import vid_pixfeed_pkg::*;

  localparam int PW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic          va, sofa, rda, nfa;
  logic [PW-1:0] pixa;
  logic          ready_a, err_a;
  logic [PW-1:0] rgb_a;
  logic [10:0]   fill_a;

  logic          vb, sofb, rdb, nfb;
  logic [PW-1:0] pixb;
  logic          ready_b, err_b;
  logic [PW-1:0] rgb_b;
  logic [4:0]    fill_b;

  vid_pixfeed #(.BPC(4), .LGFIFO(10)) dut_a (
    .i_pixclk(clk), .i_reset(rst), .i_valid(va), .o_ready(ready_a),
    .i_pixel(pixa), .i_sof(sofa), .i_rd(rda), .i_newframe(nfa),
    .o_rgb_pix(rgb_a), .o_err(err_a), .o_fill(fill_a)
  );

  vid_pixfeed #(.BPC(4), .LGFIFO(4)) dut_b (
    .i_pixclk(clk), .i_reset(rst), .i_valid(vb), .o_ready(ready_b),
    .i_pixel(pixb), .i_sof(sofb), .i_rd(rdb), .i_newframe(nfb),
    .o_rgb_pix(rgb_b), .o_err(err_b), .o_fill(fill_b)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int err_a_cnt = 0;
  int err_b_cnt = 0;
  logic [PW-1:0] q_a[$];
  logic [PW-1:0] q_b[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors: whenever a read is presented, the DUT output must match the
  // oldest expected pixel queued by the stimulus.
  always @(negedge clk) begin
    if (err_a) err_a_cnt++;
    if (!rst && rda) begin
      if (q_a.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL mon_a: read with empty scoreboard, got %0h", rgb_a);
      end else
        check("mon_a_pix", 32'(rgb_a), 32'(q_a.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (err_b) err_b_cnt++;
    if (!rst && rdb) begin
      if (q_b.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL mon_b: read with empty scoreboard, got %0h", rgb_b);
      end else
        check("mon_b_pix", 32'(rgb_b), 32'(q_b.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_a(input logic s, input logic [PW-1:0] p);
    va = 1'b1; sofa = s; pixa = p;
    tick();
    va = 1'b0; sofa = 1'b0;
  endtask

  task automatic rd_a(input logic [PW-1:0] p);
    q_a.push_back(p);
    rda = 1'b1;
    tick();
    rda = 1'b0;
  endtask

  task automatic nf_a();
    nfa = 1'b1;
    tick();
    nfa = 1'b0;
  endtask

  task automatic wr_b(input logic s, input logic [PW-1:0] p);
    vb = 1'b1; sofb = s; pixb = p;
    tick();
    vb = 1'b0; sofb = 1'b0;
  endtask

  task automatic rd_b(input logic [PW-1:0] p);
    q_b.push_back(p);
    rdb = 1'b1;
    tick();
    rdb = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    va = 0; sofa = 0; rda = 0; nfa = 0; pixa = '0;
    vb = 0; sofb = 0; rdb = 0; nfb = 0; pixb = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_fill", 32'(fill_a), 0);
    check("rst_state", 32'(dut_a.state), 32'(SYNC));
    check("rst_err", 32'(err_a), 0);
    check("rst_rgb", 32'(rgb_a), 0);
    #3 rst = 1'b0;
    tick();
    check("rel_ready_a", 32'(ready_a), 1);
    check("rel_ready_b", 32'(ready_b), 1);

    // First frame: sof pixel then three more, then frame boundary.
    wr_a(1'b1, 12'hA51);
    wr_a(1'b0, 12'h3C7);
    wr_a(1'b0, 12'h0F0);
    wr_a(1'b0, 12'hFFF);
    check("t1_armed", 32'(dut_a.state), 32'(ARMED));
    nf_a();
    check("t1_run", 32'(dut_a.state), 32'(RUN));
    check("t1_rgb", 32'(rgb_a), 32'h0A51);
    check("t1_fill", 32'(fill_a), 4);
    check("t1_noerr", 32'(err_a_cnt), 0);
    rd_a(12'hA51); rd_a(12'h3C7); rd_a(12'h0F0); rd_a(12'hFFF);
    check("t1_drained", 32'(fill_a), 0);

    // Underflow in RUN.
    rd_a(12'h000);
    check("uf_err", 32'(err_a), 1);
    check("uf_state", 32'(dut_a.state), 32'(SYNC));
    check("uf_rgb", 32'(rgb_a), 0);
    tick();
    check("uf_err_low", 32'(err_a), 0);
    check("uf_err_cnt", 32'(err_a_cnt), 1);

    // Stale non-sof data is discarded in SYNC.
    wr_a(1'b0, 12'h111);
    wr_a(1'b0, 12'h222);
    wr_a(1'b0, 12'h333);
    wr_a(1'b1, 12'h400);
    tick();
    check("sync_armed", 32'(dut_a.state), 32'(ARMED));
    check("sync_fill", 32'(fill_a), 1);

    // Full 640-pixel line.
    nf_a();
    check("line_rgb0", 32'(rgb_a), 32'h0400);
    for (int i = 1; i < 640; i++) wr_a(1'b0, 12'(i * 7 + 1));
    check("line_fill", 32'(fill_a), 640);
    rd_a(12'h400);
    for (int i = 1; i < 320; i++) rd_a(12'(i * 7 + 1));
    check("line_fill_mid", 32'(fill_a), 320);
    for (int i = 320; i < 640; i++) rd_a(12'(i * 7 + 1));
    check("line_fill_end", 32'(fill_a), 0);
    check("line_noerr", 32'(err_a_cnt), 1);

    // Frame boundary with a non-sof head.
    wr_a(1'b0, 12'h5A5);
    nf_a();
    check("nf_bad_err", 32'(err_a), 1);
    check("nf_bad_state", 32'(dut_a.state), 32'(SYNC));
    tick();
    check("nf_bad_flush", 32'(fill_a), 0);
    check("nf_bad_cnt", 32'(err_a_cnt), 2);

    // Frame boundary with a sof head keeps running.
    wr_a(1'b1, 12'h6B6);
    tick();
    check("nf_ok_armed", 32'(dut_a.state), 32'(ARMED));
    nf_a();
    rd_a(12'h6B6);
    wr_a(1'b1, 12'h7C7);
    nf_a();
    check("nf_ok_state", 32'(dut_a.state), 32'(RUN));
    check("nf_ok_rgb", 32'(rgb_a), 32'h07C7);
    check("nf_ok_cnt", 32'(err_a_cnt), 2);
    rd_a(12'h7C7);
    check("nf_ok_fill", 32'(fill_a), 0);

    // Unexpected sof on a read: error, no pop, realign on that entry.
    wr_a(1'b1, 12'h8D8);
    rd_a(12'h8D8);
    check("mis_err", 32'(err_a), 1);
    check("mis_state", 32'(dut_a.state), 32'(SYNC));
    check("mis_fill", 32'(fill_a), 1);
    tick();
    check("mis_armed", 32'(dut_a.state), 32'(ARMED));
    check("mis_cnt", 32'(err_a_cnt), 3);

    // Reset mid-line.
    nf_a();
    rd_a(12'h8D8);
    for (int i = 0; i < 100; i++) wr_a(1'b0, 12'(256 + i));
    check("rst_mid_fill", 32'(fill_a), 100);
    #2 rst = 1'b1;
    #1;
    check("arst_fill", 32'(fill_a), 0);
    check("arst_state", 32'(dut_a.state), 32'(SYNC));
    check("arst_rgb", 32'(rgb_a), 0);
    tick();
    #3 rst = 1'b0;
    tick();
    nf_a();
    check("arst_nf_ignored", 32'(dut_a.state), 32'(SYNC));
    wr_a(1'b1, 12'h9E9);
    tick();
    check("arst_armed", 32'(dut_a.state), 32'(ARMED));
    nf_a();
    check("arst_run", 32'(dut_a.state), 32'(RUN));
    check("arst_rgb_run", 32'(rgb_a), 32'h09E9);
    rd_a(12'h9E9);
    check("arst_fill_end", 32'(fill_a), 0);
    check("arst_cnt", 32'(err_a_cnt), 3);

    // Small FIFO: fill to full, then combined write/read.
    wr_b(1'b1, 12'hB00);
    for (int i = 1; i < 16; i++) wr_b(1'b0, 12'(12'hB00 + i));
    check("b_full_ready", 32'(ready_b), 0);
    check("b_full_fill", 32'(fill_b), 16);
    nfb = 1'b1; tick(); nfb = 1'b0;
    check("b_run", 32'(dut_b.state), 32'(RUN));
    vb = 1'b1; pixb = 12'hC01; q_b.push_back(12'hB00); rdb = 1'b1;
    tick();
    vb = 1'b0; rdb = 1'b0;
    check("b_pop_fill", 32'(fill_b), 15);
    check("b_pop_ready", 32'(ready_b), 1);
    vb = 1'b1; pixb = 12'hC02; q_b.push_back(12'hB01); rdb = 1'b1;
    tick();
    vb = 1'b0; rdb = 1'b0;
    check("b_wrrd_fill", 32'(fill_b), 15);
    for (int i = 2; i < 16; i++) rd_b(12'(12'hB00 + i));
    rd_b(12'hC02);
    check("b_drained", 32'(fill_b), 0);
    wr_b(1'b0, 12'hD00);
    vb = 1'b1; pixb = 12'hD01; q_b.push_back(12'hD00); rdb = 1'b1;
    tick();
    vb = 1'b0; rdb = 1'b0;
    check("b_fill1_wrrd", 32'(fill_b), 1);
    rd_b(12'hD01);
    check("b_end_fill", 32'(fill_b), 0);
    check("b_noerr", 32'(err_b_cnt), 0);

    tick();
    check("q_a_empty", 32'(q_a.size()), 0);
    check("q_b_empty", 32'(q_b.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
